hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   - Detects load-use hazards and inserts a single bubble into ID/EX.
//   - Freezes the pipeline while the multi-cycle data memory is busy, then
//     spends one RESUME cycle before returning to RUN.
//   - Raises a sticky mem_timeout and freezes for good (ERR) if the memory
//     stays busy too long. Only reset leaves ERR.
//   - Selects operand forwarding sources (MEM over WB over register file).
// Optional feature: define HAZARD_STALL_CNT_EN to build a saturating counter
// of stall cycles. When it is undefined, stall_cnt is tied to zero.
//
// Handshake/enable semantics: pc_en, ifid_en and buf_en are update enables.
// A 0 holds the stage. idex_flush = 1 loads a bubble into ID/EX. All of these
// are combinational from the current state and inputs, so a hazard acts in
// the same cycle it is seen.
// dbg_state exposes the FSM state: 0 RUN, 1 MEM_WAIT, 2 RESUME, 3 ERR.
module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_flush,
    output logic             buf_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fp,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RESUME   = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;

    logic              w_lu;
    logic              w_run_like;

    // Load-use hazard: the instruction in EX is a load whose destination
    // is a source of the instruction in ID. Register 0 never matches.
    assign w_lu = id_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (ex_rd == id_rt));

    // RESUME issues like RUN. It exists only to mark the cycle after a wait.
    assign w_run_like = (r_state == ST_RUN) || (r_state == ST_RESUME);

    // Pipeline enables: reset values while in reset, freeze on memory wait or
    // error, single bubble on load-use. mem_busy takes priority over load-use.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        buf_en     = 1'b0;
        if (rst_n) begin
            if (w_run_like && !mem_busy && w_lu) begin
                idex_flush = 1'b1;
            end else if (w_run_like && !mem_busy) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_flush = 1'b0;
                buf_en     = 1'b1;
            end else begin
                idex_flush = 1'b0;
            end
        end
    end

    // Forwarding selects: MEM (10) beats WB (01). Register 0 is never
    // forwarded. The selects are forced to 00 in reset and in ERR.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n && (r_state != ST_ERR)) begin
            if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rs)) begin
                fwd_a = 2'b10;
            end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs)) begin
                fwd_a = 2'b01;
            end
            if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rt)) begin
                fwd_b = 2'b10;
            end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign fp          = (fwd_a != 2'b00) | (fwd_b != 2'b00);
    assign mem_timeout = r_timeout;
    assign dbg_state   = r_state;

    // Control FSM with its wait counter and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_RESUME: begin
                    if (mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end else begin
                        r_state    <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_busy) begin
                        r_state    <= ST_RESUME;
                    end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        r_state    <= ST_ERR;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state   <= ST_ERR;
                    r_timeout <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of every cycle in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed steps with a reference model feeding
// an expected-value queue that is checked once per cycle.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;
  localparam int EW       = 12 + CNT_W;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_RES = 2'd2;
  localparam logic [1:0] S_ERR = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_valid, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mem_busy;
  logic pc_en, ifid_en, idex_flush, buf_en, fp, mem_timeout;
  logic [1:0] fwd_a, fwd_b, dbg_state;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_flush(idex_flush), .buf_en(buf_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fp(fp),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int bubbles;

  // reference model state
  logic [1:0]       m_state;
  int               m_cnt;
  logic             m_to;
  logic [CNT_W-1:0] m_stall;

  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == r) return 2'b10;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [EW-1:0] model_out();
    logic [3:0] en;
    logic [1:0] fa, fb;
    logic lu, f;
    lu = id_valid & ex_memread & ex_regwrite & (ex_rd != 5'd0) &
         ((ex_rd == id_rs) | (ex_rd == id_rt));
    en = 4'b0010;  // pc_en, ifid_en, idex_flush, buf_en
    fa = 2'b00;
    fb = 2'b00;
    if (rst_n) begin
      if ((m_state == S_RUN || m_state == S_RES) && !mem_busy)
        en = lu ? 4'b0010 : 4'b1101;
      else
        en = 4'b0000;
      if (m_state != S_ERR) begin
        fa = fsel(id_rs);
        fb = fsel(id_rt);
      end
    end
    f = (fa != 2'b00) || (fb != 2'b00);
    return {m_state, m_to, f, fa, fb, en, m_stall};
  endfunction

  task automatic model_reset();
    m_state = S_RUN;
    m_cnt   = 0;
    m_to    = 1'b0;
    m_stall = '0;
  endtask

  // advance the model across one edge given the pre-edge expected outputs
  task automatic model_advance(input logic [EW-1:0] e);
`ifdef HAZARD_STALL_CNT_EN
    if (!e[CNT_W+3] && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
`endif
    case (m_state)
      S_RUN, S_RES: begin
        if (mem_busy) begin m_state = S_MW; m_cnt = 1; end
        else m_state = S_RUN;
      end
      S_MW: begin
        if (!mem_busy) m_state = S_RES;
        else if (m_cnt == MAX_WAIT) begin m_state = S_ERR; m_to = 1'b1; end
        else m_cnt++;
      end
      default: m_state = S_ERR;
    endcase
  endtask

  task automatic check_out(input string tag);
    logic [EW-1:0] e, o;
    o = {dbg_state, mem_timeout, fp, fwd_a, fwd_b, pc_en, ifid_en, idex_flush, buf_en, stall_cnt};
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=<queue empty>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        mismatched++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // one cycle: predict, check at negedge, cross the edge, update model
  task automatic step(input string tag);
    logic [EW-1:0] e;
    e = model_out();
    exp_q.push_back(e);
    @(negedge clk);
    if (idex_flush && rst_n) bubbles++;
    check_out(tag);
    @(posedge clk);
    model_advance(e);
    #1;
  endtask

  // check immediately (used right after an asynchronous reset assertion)
  task automatic check_now(input string tag);
    exp_q.push_back(model_out());
    check_out(tag);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_valid = 0;
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    mem_busy = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_rd = rd; ex_regwrite = 1; ex_memread = 1; id_valid = 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    clear_inputs();
    // forwarding-worthy inputs during reset must still give reset outputs
    id_rs = 5'd7; id_rt = 5'd7; mem_rd = 5'd7; mem_regwrite = 1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold");
    rst_n = 1'b1;
    clear_inputs();
    step("idle");
    step("idle2");

    // load-use on rs: exactly one bubble
    bubbles = 0;
    set_load(5'd5); id_rs = 5'd5;
    step("lu_rs");
    clear_inputs();
    step("lu_rs_after");
    step("lu_rs_after2");
    chk("lu_bubble_count", bubbles, 1);

    // load-use via rt
    set_load(5'd9); id_rt = 5'd9; id_rs = 5'd2;
    step("lu_rt");
    // register 0 never stalls
    set_load(5'd0); id_rs = 5'd0; id_rt = 5'd0;
    step("lu_r0");
    // bubble in ID never stalls
    set_load(5'd5); id_rs = 5'd5; id_valid = 0;
    step("lu_bubble_id");
    clear_inputs();

    // forwarding priority and fallbacks
    mem_rd = 5'd7; wb_rd = 5'd7; mem_regwrite = 1; wb_regwrite = 1;
    id_rs = 5'd7; id_rt = 5'd7;
    step("fwd_mem");
    mem_regwrite = 0;
    step("fwd_wb");
    mem_regwrite = 1; mem_rd = 5'd3; id_rs = 5'd3;
    step("fwd_split");
    mem_rd = 5'd0; wb_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    step("fwd_r0");
    for (int i = 0; i < 24; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_valid = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 3)); ex_regwrite = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom_range(0, 1));
      step("rand_run");
    end
    clear_inputs();
    step("idle3");

    // memory wait: 4 busy cycles, exit, resume, run
    mem_busy = 1;
    repeat (4) step("mw_busy");
    mem_busy = 0;
    step("mw_exit");
    step("mw_resume");
    step("mw_run");
    chk("mw_back_to_run", int'(dbg_state), int'(S_RUN));

    // busy again during RESUME goes straight back to MEM_WAIT
    mem_busy = 1;
    repeat (2) step("rw_busy");
    mem_busy = 0;
    step("rw_exit");
    mem_busy = 1;
    step("rw_resume_busy");
    mem_busy = 0;
    step("rw_exit2");
    step("rw_resume");
    step("rw_run");

    // load-use and mem_busy together: wait wins, bubble comes on resume
    bubbles = 0;
    set_load(5'd4); id_rs = 5'd4;
    mem_busy = 1;
    step("sim_enter");
    step("sim_wait");
    mem_busy = 0;
    step("sim_exit");
    step("sim_resume_lu");
    clear_inputs();
    step("sim_run");
    chk("sim_bubble_count", bubbles, 1);

    // asynchronous reset in the middle of a wait
    mem_busy = 1;
    repeat (3) step("rst_mw_busy");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("rst_mw_immediate");
    mem_busy = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_mw_after");
    chk("rst_mw_state", int'(dbg_state), int'(S_RUN));

    // timeout: busy held 20 cycles
    mem_busy = 1;
    for (int i = 1; i <= 20; i++) begin
      step("to_busy");
      if (i == 14) chk("to_low_early", int'(mem_timeout), 0);
    end
    chk("to_set", int'(mem_timeout), 1);
    mem_busy = 0;
    mem_rd = 5'd7; mem_regwrite = 1; id_rs = 5'd7; id_rt = 5'd7;
    repeat (3) step("err_frozen");
    set_load(5'd7);
    step("err_lu");
    chk("err_stays", int'(dbg_state), int'(S_ERR));

    // reset from ERR
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("rst_err_immediate");
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_err_after");
    step("rst_err_after2");

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
